// File: rtl/channel_4_noise_voice_pkg.sv
// channel_4_noise_voice_pkg: shared LFSR geometry and channel 4 phase-delta constants
package channel_4_noise_voice_pkg;
    localparam int LFSR_W = 15;
    localparam int LONG_TAP = 1;
    localparam int SHORT_TAP = 6;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'h0001;
    localparam logic [31:0] CH4_DELTA_REST = 32'h0000_0000;
    localparam logic [31:0] CH4_DELTA_HALF = 32'h8000_0000;
    localparam logic [31:0] CH4_DELTA_MAX = 32'hFFFF_FFFF;
endpackage

// File: rtl/channel_4_noise_voice_if.sv
// channel_4_noise_voice_if: sequencer-to-voice control and sample output bundle
interface channel_4_noise_voice_if
    import channel_4_noise_voice_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16
);
    logic i_sample_stb;
    logic i_restart;
    logic i_short_mode;
    logic [31:0] i_phase_delta;
    logic [8:0] i_envelope;
    logic signed [SAMPLE_WIDTH-1:0] o_sample;
    logic o_sample_valid;
    logic [LFSR_W-1:0] o_lfsr;
    modport master (
        output i_sample_stb, i_restart, i_short_mode, i_phase_delta, i_envelope,
        input o_sample, o_sample_valid, o_lfsr
    );
    modport slave (
        input i_sample_stb, i_restart, i_short_mode, i_phase_delta, i_envelope,
        output o_sample, o_sample_valid, o_lfsr
    );
endinterface

// File: rtl/channel_4_noise_voice_lfsr.sv
// noise_lfsr15: 15-bit right-shifting noise LFSR with long/short tap select
// An all-zero state would lock up, so it reloads the seed on the following cycle.
module noise_lfsr15
    import channel_4_noise_voice_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = DEFAULT_SEED
) (
    input logic i_clk,
    input logic i_rst,
    input logic step,
    input logic short_mode,
    output logic [LFSR_W-1:0] lfsr
);
    logic fb;
    always_comb fb = lfsr[0] ^ (short_mode ? lfsr[SHORT_TAP] : lfsr[LONG_TAP]);
    always_ff @(posedge i_clk) begin
        if (i_rst || lfsr == '0) lfsr <= LFSR_SEED;
        else if (step) lfsr <= {fb, lfsr[LFSR_W-1:1]};
    end
endmodule

// File: rtl/channel_4_noise_voice.sv
// channel_4_noise_voice: phase accumulator clocks a noise LFSR that signs the envelope
// Stage 1 latches on the strobe; stage 2 forms the sample from the post-step LFSR.
module channel_4_noise_voice
    import channel_4_noise_voice_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = DEFAULT_SEED
) (
    input logic i_clk,
    input logic i_rst,
    channel_4_noise_voice_if.slave bus
);
    logic [31:0] acc;
    logic [32:0] sum;
    logic step;
    logic [8:0] env;
    logic mute;
    logic v1;
    logic signed [SAMPLE_WIDTH-1:0] env_s;
    logic signed [SAMPLE_WIDTH-1:0] sample;
    logic sample_valid;
    logic [LFSR_W-1:0] lfsr;
    always_comb begin
        sum = {1'b0, acc} + {1'b0, bus.i_phase_delta};
        step = bus.i_sample_stb && !bus.i_restart && sum[32];
        env_s = $signed({{(SAMPLE_WIDTH-9){1'b0}}, env});
    end
    noise_lfsr15 #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .step(step),
        .short_mode(bus.i_short_mode),
        .lfsr(lfsr)
    );
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc <= '0;
            env <= '0;
            mute <= 1'b1;
            v1 <= 1'b0;
            sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            v1 <= bus.i_sample_stb;
            sample_valid <= v1;
            if (bus.i_restart) acc <= '0;
            else if (bus.i_sample_stb) acc <= sum[31:0];
            if (bus.i_sample_stb) begin
                env <= bus.i_envelope;
                mute <= bus.i_phase_delta == 32'd0;
            end
            if (v1) sample <= mute ? '0 : (lfsr[0] ? -env_s : env_s);
        end
    end
    always_comb begin
        bus.o_sample = sample;
        bus.o_sample_valid = sample_valid;
        bus.o_lfsr = lfsr;
    end
endmodule

// File: tb/tb_channel_4_noise_voice.sv
// tb_channel_4_noise_voice: directed and random stimulus against a sample-level reference model
module tb_channel_4_noise_voice;
    typedef struct { int due; longint val; } pend_t;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    channel_4_noise_voice_if #(.SAMPLE_WIDTH(16)) bus();
    channel_4_noise_voice #(.SAMPLE_WIDTH(16), .LFSR_SEED(15'h0001)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus.slave)
    );
    longint unsigned m_acc;
    int m_lfsr;
    longint m_samp;
    int edge_n = 0;
    pend_t pq[$];
    task automatic check(input string tag, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask
    // Noise step: new top bit is the XOR of bit 0 and the selected tap
    function automatic int next15(input int s, input bit sh);
        int fb = (s ^ (s >> (sh ? 6 : 1))) & 1;
        return (s >> 1) | (fb << 14);
    endfunction
    task automatic tick();
        bit ev = 0;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_acc = 0;
            m_lfsr = 1;
            m_samp = 0;
            pq.delete();
        end else begin
            if (pq.size() > 0 && pq[0].due == edge_n) begin
                ev = 1;
                m_samp = pq[0].val;
                void'(pq.pop_front());
            end
            if (bus.i_sample_stb) begin
                longint unsigned s = m_acc + longint'(bus.i_phase_delta);
                if (bus.i_restart) m_acc = 0;
                else begin
                    if (s >= 64'h1_0000_0000) m_lfsr = next15(m_lfsr, bus.i_short_mode);
                    m_acc = s % 64'h1_0000_0000;
                end
                pq.push_back('{edge_n + 1,
                    bus.i_phase_delta == 0 ? 0 : ((m_lfsr & 1) ? -longint'(bus.i_envelope) : longint'(bus.i_envelope))});
            end else if (bus.i_restart) m_acc = 0;
        end
        #1;
        check("valid", longint'(bus.o_sample_valid), longint'(ev));
        check("sample", longint'(bus.o_sample), m_samp);
        check("lfsr", longint'(bus.o_lfsr), longint'(m_lfsr));
    endtask
    task automatic drive(input bit stb, input bit rs, input bit sh, input logic [31:0] d, input logic [8:0] e);
        bus.i_sample_stb = stb;
        bus.i_restart = rs;
        bus.i_short_mode = sh;
        bus.i_phase_delta = d;
        bus.i_envelope = e;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask
    task automatic period(input bit sh, input int want, input string tag);
        int steps = 0;
        int prev;
        int seen[3];
        do_reset();
        drive(1, 0, sh, 32'hFFFF_FFFF, 9'd100);
        prev = int'(bus.o_lfsr);
        for (int i = 0; i < 40000; i++) begin
            tick();
            if (int'(bus.o_lfsr) != prev) begin
                if (steps < 3) seen[steps] = int'(bus.o_lfsr);
                steps++;
                prev = int'(bus.o_lfsr);
                if (prev == 1) break;
            end
        end
        check(tag, longint'(steps), longint'(want));
        if (!sh) begin
            check("long_step1", longint'(seen[0]), 64'h4000);
            check("long_step2", longint'(seen[1]), 64'h2000);
            check("long_step3", longint'(seen[2]), 64'h1000);
        end
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
    endtask
    initial begin
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        check("idle_lfsr", longint'(bus.o_lfsr), 64'h1);
        drive(1, 0, 0, 32'h8000_0000, 9'd20);
        tick();
        drive(0, 0, 0, 32'h8000_0000, 9'd20);
        tick();
        tick();
        check("half_first", longint'(bus.o_sample), -64'sd20);
        for (int i = 0; i < 7; i++) tick();
        drive(1, 0, 0, 32'h8000_0000, 9'd20);
        tick();
        drive(0, 0, 0, 32'h8000_0000, 9'd20);
        check("half_carry_lfsr", longint'(bus.o_lfsr), 64'h4000);
        tick();
        tick();
        check("half_second", longint'(bus.o_sample), 64'sd20);
        period(0, 32767, "long_period");
        period(1, 93, "short_period");
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 32'd0, 9'd511);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, i == 3, 0, 32'hC000_0000, 9'(i * 30));
            tick();
            if (i == 3) check("acc_restart", longint'(dut.acc), 0);
        end
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        drive(1, 0, 0, 32'h1234_5678, 9'd77);
        tick();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("acc_after_rst", longint'(dut.acc), 0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            rst = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)), d, 9'($urandom_range(0, 511)));
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
